// File: rtl/cacheline_adapter_pkg.sv
// Constants and state encoding shared between the cache and its memory-side line adapter.
package cache_types;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned LINE_W = BEAT_W * BEATS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_BURST,
    ST_RESP
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Serialises whole-line cache read/write requests onto a beat-wide burst memory port
// and reassembles read beats into a line with a single-cycle completion pulse.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int unsigned BEAT_W = cache_types::BEAT_W,
  parameter int unsigned BEATS  = cache_types::BEATS,
  localparam int unsigned LINE_W = BEAT_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adapter_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic              req_present;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];
  assign dfp_rdata        = rline_q;

  // The originating request is still held, same direction and same line.
  assign req_present = (wr_q ? dfp_write : dfp_read) &&
                       (dfp_addr[31:OFF_W] == addr_q[31:OFF_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    dfp_resp   = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Write has priority if a misbehaving requester raises both.
        if (dfp_write) begin
          addr_d  = {dfp_addr[31:OFF_W], OFF_W'(0)};
          wline_d = dfp_wdata;
          wr_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_WR_BURST;
        end else if (dfp_read) begin
          addr_d  = {dfp_addr[31:OFF_W], OFF_W'(0)};
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        bmem_addr = addr_q;
        // Beats tagged for another line belong to someone else and are dropped.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          rline_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline_q[cnt_q*BEAT_W +: BEAT_W];
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RESP: begin
        bmem_addr = addr_q;
        dfp_resp  = req_present;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: a vector table of line transactions plus reset and chaining sequences.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_cmp;
  int n_bad;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           stall;     // read: ready-low cycles; write: 1 = ready on alternate cycles
    int           gap;       // read: rvalid-low cycles before beat 1
    bit           withdraw;  // read: drop dfp_read while beat 2 is delivered
    bit           spur;      // read: inject a foreign-tagged beat before beat 2
    logic [31:0]  exp_baddr;
    bit           exp_resp;
    int           exp_lat;   // -1: no response expected
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [255:0] line,
                              input int stall, input int gap, input bit withdraw, input bit spur,
                              input logic [31:0] exp_baddr, input bit exp_resp, input int exp_lat,
                              input logic [255:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.line = line; v.stall = stall; v.gap = gap;
    v.withdraw = withdraw; v.spur = spur; v.exp_baddr = exp_baddr;
    v.exp_resp = exp_resp; v.exp_lat = exp_lat; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Plays requester and memory for one transaction; cycle 0 is the cycle the request is raised.
  task automatic run_vec(input vec_t v, input int tail, input string nm);
    int c, bi, k, stall_left, gap_left, resp_cnt, resp_cyc, p2, phase;
    bit addr_chk, spur_done;
    c = 0; bi = 0; k = 0; p2 = 0; phase = 0;
    stall_left = v.stall; gap_left = v.gap;
    resp_cnt = 0; resp_cyc = -1; addr_chk = 0; spur_done = 0;
    dfp_addr = v.addr;
    if (v.wr) begin
      dfp_wdata = v.line;
      dfp_write = 1'b1;
    end else begin
      dfp_read = 1'b1;
    end
    while (phase != 3) begin
      @(posedge clk); #1;
      c++;
      if (c > 100) begin
        chk({nm, ".timeout"}, 256'(c), 256'(0));
        break;
      end
      if (dfp_resp) begin
        resp_cnt++;
        if (resp_cyc < 0) resp_cyc = c;
      end
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      case (phase)
        0: begin
          if (!v.wr && bmem_read) begin
            if (!addr_chk) begin
              chk({nm, ".baddr"}, 256'(bmem_addr), 256'(v.exp_baddr));
              addr_chk = 1;
            end
            if (stall_left > 0) stall_left--;
            else begin
              bmem_ready = 1'b1;
              phase = 1;
            end
          end else if (v.wr && bmem_write) begin
            if (!addr_chk) begin
              chk({nm, ".baddr"}, 256'(bmem_addr), 256'(v.exp_baddr));
              addr_chk = 1;
            end
            chk($sformatf("%s.wbeat%0d", nm, bi), 256'(bmem_wdata), 256'(v.line[bi*64 +: 64]));
            if (v.stall == 0 || (k % 2) == 1) begin
              bmem_ready = 1'b1;
              bi++;
              if (bi == 4) phase = 2;
            end
            k++;
          end
        end
        1: begin
          if (v.withdraw && bi == 2) dfp_read = 1'b0;
          if (gap_left > 0 && bi == 1) begin
            gap_left--;
          end else if (v.spur && bi == 2 && !spur_done) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_2000;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            spur_done   = 1;
          end else begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = v.exp_baddr;
            bmem_rdata  = v.line[bi*64 +: 64];
            bi++;
            if (bi == 4) phase = 2;
          end
        end
        default: begin
          p2++;
          chk($sformatf("%s.bus_quiet%0d", nm, p2), 256'(bmem_read | bmem_write), 256'(0));
          if (p2 >= 2) begin
            dfp_read  = 1'b0;
            dfp_write = 1'b0;
          end
          if (p2 >= tail) phase = 3;
        end
      endcase
    end
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    chk({nm, ".resp_cnt"}, 256'(resp_cnt), 256'(v.exp_resp));
    if (v.exp_lat >= 0) chk({nm, ".latency"}, 256'(resp_cyc), 256'(v.exp_lat));
    chk({nm, ".rdata"}, dfp_rdata, v.exp_rdata);
    chk({nm, ".idle_addr"}, 256'(bmem_addr), 256'(0));
  endtask

  logic [255:0] l1, l2, l3, l4, l5, lw1, lw2, lw3;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2  = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    l3  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0};
    l4  = {64'hC0DE_0003_C0DE_0003, 64'hC0DE_0002_C0DE_0002, 64'hC0DE_0001_C0DE_0001, 64'hC0DE_0000_C0DE_0000};
    l5  = {64'h7777_0000_7777_0003, 64'h7777_0000_7777_0002, 64'h7777_0000_7777_0001, 64'h7777_0000_7777_0000};
    lw1 = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    lw2 = {64'hFACE_0000_0000_0003, 64'hFACE_0000_0000_0002, 64'hFACE_0000_0000_0001, 64'hFACE_0000_0000_0000};
    lw3 = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222, 64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA};

    //           wr  addr          line stall gap wd sp  exp_baddr     resp lat exp_rdata
    vecs[0] = mk(0, 32'h0000_1044, l1,  0,    0,  0, 0,  32'h0000_1040, 1,   6,  l1);
    vecs[1] = mk(1, 32'h8000_0020, lw1, 1,    0,  0, 0,  32'h8000_0020, 1,   9,  l1);
    vecs[2] = mk(0, 32'h0000_1040, l2,  0,    0,  1, 0,  32'h0000_1040, 0,  -1,  l2);
    vecs[3] = mk(0, 32'h0000_1040, l3,  1,    0,  0, 1,  32'h0000_1040, 1,   8,  l3);
    vecs[4] = mk(0, 32'h1234_567F, l4,  2,    1,  0, 0,  32'h1234_5660, 1,   9,  l4);
    vecs[5] = mk(1, 32'hFFFF_FFFF, lw3, 0,    0,  0, 0,  32'hFFFF_FFE0, 1,   5,  l4);

    #1;
    chk("reset.resp",   256'(dfp_resp), 256'(0));
    chk("reset.rdata",  dfp_rdata, 256'(0));
    chk("reset.bus",    256'({bmem_read, bmem_write}), 256'(0));
    chk("reset.baddr",  256'(bmem_addr), 256'(0));
    chk("reset.wdata",  256'(bmem_wdata), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 3, $sformatf("v%0d", i));

    // Asynchronous reset while beat 2 of a write is on the bus.
    dfp_addr = 32'h4000_0000; dfp_wdata = lw2; dfp_write = 1'b1; bmem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.pre_write", 256'(bmem_write), 256'(1));
    chk("rst_mid.pre_beat2", 256'(bmem_wdata), 256'(lw2[128 +: 64]));
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.write", 256'(bmem_write), 256'(0));
    chk("rst_mid.baddr", 256'(bmem_addr), 256'(0));
    chk("rst_mid.wdata", 256'(bmem_wdata), 256'(0));
    chk("rst_mid.resp",  256'(dfp_resp), 256'(0));
    chk("rst_mid.rdata", dfp_rdata, 256'(0));
    dfp_write = 1'b0; bmem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_vec(mk(1, 32'h4000_0000, lw2, 0, 0, 0, 0, 32'h4000_0000, 1, 5, 256'(0)), 3, "rst_after");

    // Read, then a write raised in the cycle right after its response.
    run_vec(mk(0, 32'h0000_3000, l5, 0, 0, 0, 0, 32'h0000_3000, 1, 6, l5), 2, "b2b_rd");
    chk("b2b.idle_gap", 256'({bmem_read, bmem_write, dfp_resp}), 256'(0));
    run_vec(mk(1, 32'h0000_3020, lw3, 0, 0, 0, 0, 32'h0000_3020, 1, 5, l5), 3, "b2b_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache's downward-facing port (dfp). It accepts whole-line (256-bit) read and write requests from the pipelined cache and serialises them onto the 64-bit burst memory (bmem) interface as 4-beat bursts. Read beats are reassembled into a line, and the cache gets a single-cycle response. It sits between the instruction/data cache and the banked memory model, one instance per cache.

## Interface
- BEAT_W, default 64: bmem data width.
- BEATS, default 4: beats per line; LINE_W = BEAT_W*BEATS = 256.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- dfp_addr  in  32  line request address; bits [4:0] ignored.
- dfp_read  in  1  line read request, held until dfp_resp.
- dfp_write  in  1  line write request, held until dfp_resp.
- dfp_wdata  in  LINE_W  write line, valid while dfp_write.
- dfp_rdata  out  LINE_W  read line, valid in the dfp_resp cycle.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  burst address, always line-aligned.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat data.
- bmem_ready  in  1  memory accepts the command/beat this cycle.
- bmem_raddr  in  32  address tag of a returning read beat.
- bmem_rdata  in  BEAT_W  read beat data.
- bmem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE: if dfp_write, latch {dfp_addr[31:5],5'b0} and dfp_wdata, clear beat count, go to WR_BURST. Otherwise, if dfp_read, latch the address and go to RD_REQ. Write wins if both are asserted; both asserted is illegal for the requester.
- RD_REQ: drive bmem_read=1 and bmem_addr=latched line address. When bmem_ready=1, go to RD_DATA with cnt=0.
- RD_DATA: on each bmem_rvalid with bmem_raddr == latched address, store bmem_rdata into line bits [cnt*64 +: 64] and increment cnt. A beat with a mismatched raddr is ignored. Capturing beat BEATS-1 moves to RESP.
- WR_BURST: drive bmem_write=1, bmem_addr=latched address, and bmem_wdata = line[cnt*64 +: 64]. Advance cnt only on cycles where bmem_ready=1. Acceptance of beat BEATS-1 moves to RESP.
- RESP: if the request is still present (same direction as latched, and dfp_addr[31:5] matches), assert dfp_resp=1 for this cycle. Otherwise suppress dfp_resp; this covers a cache that abandoned the request on branch_mispredict. Always return to IDLE.
- Once issued to bmem, a burst always runs to completion; withdrawal only suppresses the response.
- dfp_rdata is the registered line buffer. It holds its value until the next read overwrites it.
- In every state other than those above, bmem_read, bmem_write and dfp_resp are 0. bmem_addr and bmem_wdata are 0 in IDLE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, line buffer=0, latched address=0. Outputs: dfp_resp=0, dfp_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
- Reset mid-burst: the burst is abandoned immediately and no response is given. The memory model is reset with it.
- Minimum read latency, with the request sampled at cycle 0, ready at cycle 1 and rvalid at cycles 2–5: dfp_resp at cycle 6.
- Minimum write latency, with ready held high: beats at cycles 1–4, dfp_resp at cycle 5.
- Stalls: each bmem_ready=0 cycle adds one cycle. Gaps in rvalid add cycles one for one.
- At most one outstanding request. After RESP, at least one IDLE cycle precedes the next acceptance.
- The requester must deassert dfp_read/dfp_write in the cycle after dfp_resp.
- cnt is log2(BEATS) bits. It wraps to 0 on leaving RD_DATA or WR_BURST and never overflows within a burst.

## Structure
- Package cache_types holds the `adapter_state_t` enum plus the BEAT_W/BEATS/LINE_W constants shared with the cache.
- No sub-module is warranted. The line buffer, counter and FSM sit in a single module: one always_ff with async reset, one always_comb for next-state and outputs.

## Test plan
- Read, zero stall: dfp_read at 0x0000_1044 with beats 0x11…, 0x22…, 0x33…, 0x44… → bmem_addr=0x0000_1040; dfp_resp at cycle 6 with dfp_rdata = {0x44…, 0x33…, 0x22…, 0x11…}.
- Write with stalls: dfp_write at 0x8000_0020 with line = 0xDEADBEEF pattern; bmem_ready low on alternate cycles → 4 beats emitted low-first, each held until ready; a single dfp_resp follows the last accepted beat.
- Withdrawal: drop dfp_read two cycles into RD_DATA → all 4 beats are still consumed; no dfp_resp; IDLE afterwards; a new read then completes normally.
- Spurious beat: an rvalid with raddr=0x0000_2000 during a 0x0000_1040 read → ignored; cnt and the line buffer are unchanged.
- Async reset during WR_BURST beat 2 → outputs are 0 immediately, without a clock edge; the next request starts from beat 0.
- Back-to-back: read, then write the next cycle after resp → at least one IDLE cycle between the two; both complete with the correct data.
